// File: rtl/pattern_detect_mealy_pkg.sv
// ============================================================================
// Module : pattern_pkg
// Brief  : Shared types and helpers for the Mealy serial-pattern detector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pattern_pkg;

    typedef enum logic [1:0] {
        S_UNARMED = 2'd0,
        S_FILL    = 2'd1,
        S_ARMED   = 2'd2
    } pat_state_t;

    // Width of the fill counter; it only ever needs to reach PAT_W-1.
    function automatic int fill_width(input int pat_w);
        return (pat_w < 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_detect_mealy_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with synchronous clear and registered flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] c_MAX = '1;

    logic [W-1:0] r_cnt;
    logic         r_sat;
    logic [W-1:0] w_next;

    assign w_next = r_cnt + 1'b1;

    // Clear outranks a coincident increment; r_sat tracks r_cnt == c_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (inc && !r_sat) begin
            r_cnt <= w_next;
            r_sat <= (w_next == c_MAX);
        end
    end

    assign cnt = r_cnt;
    assign sat = r_sat;

endmodule

`default_nettype wire

// File: rtl/pattern_detect_mealy.sv
// ============================================================================
// Module : pattern_detect_mealy
// Brief  : Mealy detector of a loadable PAT_W-bit serial pattern with match counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pattern_detect_mealy
    import pattern_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             a,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W      = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] c_FILL_LAST = FILL_W'(PAT_W - 2);

    pat_state_t        r_state;
    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill_cnt;
    logic [PAT_W-2:0]  w_hist_shift;
    logic              w_match;
    logic              w_y;

    generate
        if (PAT_W == 2) begin : g_shift_1b
            assign w_hist_shift = a;
        end else begin : g_shift_wide
            assign w_hist_shift = {r_hist[PAT_W-3:0], a};
        end
    endgenerate

    assign w_match = ({r_hist, a} == r_pat);
    // A load cycle never reports a match: its bit is discarded.
    assign w_y     = (r_state == S_ARMED) & in_valid & ~pat_load & w_match;
    assign y       = w_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_UNARMED;
            r_pat      <= '0;
            r_hist     <= '0;
            r_fill_cnt <= '0;
        end else if (pat_load) begin
            r_pat      <= pat_in;
            r_hist     <= '0;
            r_fill_cnt <= '0;
            r_state    <= S_FILL;
        end else if (in_valid) begin
            case (r_state)
                S_FILL: begin
                    r_hist     <= w_hist_shift;
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                    if (r_fill_cnt == c_FILL_LAST) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    // Non-overlapping mode consumes the completing bit.
                    if (w_match && !overlap) begin
                        r_hist     <= '0;
                        r_fill_cnt <= '0;
                        r_state    <= S_FILL;
                    end else begin
                        r_hist <= w_hist_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (w_y),
        .cnt     (match_cnt),
        .sat     (cnt_sat)
    );

endmodule

`default_nettype wire

// File: tb/tb_pattern_detect_mealy.sv
// ============================================================================
// Module : tb_pattern_detect_mealy
// Brief  : Directed self-checking bench for pattern_detect_mealy (PAT_W=4, CNT_W=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pattern_detect_mealy;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int c_MAX = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             a;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap;
    logic             cnt_clr;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    pattern_detect_mealy #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .a         (a),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .y         (y),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check y mid-cycle, check counter after the edge.
    task automatic step(input logic v, input logic b, input logic ld,
                        input logic clr, input logic ey);
        logic ey_pop;
        @(negedge clk);
        in_valid = v;
        a        = b;
        pat_load = ld;
        cnt_clr  = clr;
        exp_q.push_back(ey);
        #1;
        ey_pop = exp_q.pop_front();
        chk("y", 32'(y), 32'(ey_pop));
        @(posedge clk);
        #1;
        if (clr) exp_cnt = 0;
        else if (ey_pop && exp_cnt < c_MAX) exp_cnt++;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
        chk("match_cnt", 32'(match_cnt), 32'(exp_cnt));
        chk("cnt_sat", 32'(cnt_sat), 32'(exp_cnt == c_MAX));
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic ov);
        pat_in  = pat;
        overlap = ov;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Bits and expected y given MSB-first; n valid bits back to back.
    task automatic run(input logic [15:0] bits, input logic [15:0] ey, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0, ey[i]);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        a        = 1'b0;
        pat_load = 1'b0;
        pat_in   = '0;
        overlap  = 1'b1;
        cnt_clr  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_sat", 32'(cnt_sat), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Unarmed: stream ignored
        run(16'b1011, 16'b0000, 4);

        // Overlapping 1011
        load(4'b1011, 1'b1);
        run(16'b1011011, 16'b0001001, 7);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 1010 overlapping, then non-overlapping
        load(4'b1010, 1'b1);
        run(16'b101010, 16'b000101, 6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        load(4'b1010, 1'b0);
        run(16'b101010, 16'b000100, 6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Gaps of in_valid=0 between valid bits
        load(4'b1011, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Saturation at 3, then clear coincident with a match
        load(4'b1011, 1'b1);
        run(16'b1011011011011, 16'b0001001001001, 13);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset just before a completing bit
        load(4'b1011, 1'b1);
        run(16'b1011, 16'b0001, 4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 1'b1;
        reset_n  = 1'b0;
        #1;
        exp_cnt = 0;
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
        chk("mid_rst_sat", 32'(cnt_sat), 32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run(16'b10111011, 16'b00000000, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pattern_detect_mealy.md
Name: pattern_detect_mealy

Overview:
Parametrised Mealy serial-pattern detector, successor to the fixed two-bit "01" detector.
- Compares a 1-bit serial stream against a runtime-loadable PAT_W-bit pattern.
- Supports overlapping and non-overlapping match modes.
- Counts matches in a saturating counter.
- Sits on serial control/status lines; y feeds downstream logic in the same cycle (Mealy).

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..32.
CNT_W, 8, match counter width; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  a carries a valid stream bit this cycle.
a  input  1  serial data bit.
pat_load  input  1  load pat_in as the new pattern and restart detection.
pat_in  input  PAT_W  pattern; MSB is the first bit expected on the stream.
overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle.
cnt_clr  input  1  synchronous clear of match_cnt.
y  output  1  Mealy match pulse, combinational from a, in_valid and registered state.
match_cnt  output  CNT_W  number of matches since reset/clear, saturating.
cnt_sat  output  1  match_cnt is at all-ones.

Behaviour:
- Reset (reset_n=0, async):
  - state=S_UNARMED; pat_reg, hist, fill_cnt and match_cnt = 0.
  - y=0, cnt_sat=0.
- States (typedef enum): S_UNARMED, S_FILL, S_ARMED.
  - S_UNARMED: no pattern loaded yet; y=0; stream ignored. pat_load -> S_FILL.
  - S_FILL: fill_cnt < PAT_W-1.
    - Each in_valid shifts a into hist (hist <= {hist[PAT_W-3:0], a}) and increments fill_cnt.
    - When fill_cnt reaches PAT_W-1 -> S_ARMED.
    - y=0.
  - S_ARMED: window = {hist, a}.
    - y = in_valid & (window == pat_reg).
    - On in_valid with y=0: shift a into hist; stay in S_ARMED.
    - On y=1 with overlap=1: shift; stay in S_ARMED.
    - On y=1 with overlap=0: clear hist and fill_cnt; -> S_FILL. The completing bit is not reused.
- hist is PAT_W-1 bits wide; the newest bit is at the LSB.
- in_valid=0: no state, hist or fill_cnt change; y=0.
- pat_load (any state except reset):
  - Next cycle: pat_reg=pat_in, hist=0, fill_cnt=0, state=S_FILL.
  - The bit presented in the load cycle is discarded; y is forced 0 in the load cycle.
  - pat_load has priority over in_valid.
- Counter:
  - match_cnt increments on each cycle with y=1.
  - Holds at 2^CNT_W-1 (no wrap). cnt_sat = (match_cnt == all-ones), registered with the counter.
  - cnt_clr: match_cnt <= 0 next cycle.
  - cnt_clr and y=1 in the same cycle: the clear wins; count = 0, not 1.
  - pat_load does not affect match_cnt.
- Latency: y has 0 cycles latency from the completing bit; match_cnt updates 1 cycle later.
- reset_n asserted mid-stream: partial window is lost; detection requires a new pat_load.

Decomposition:
- Package pattern_pkg:
  - state typedef pat_state_t {S_UNARMED, S_FILL, S_ARMED} (logic [1:0]).
  - Localparam-derived FILL_W = $clog2(PAT_W).
- Sub-module sat_counter:
  - Parameter W.
  - Ports: clk, reset_n, clr, inc, cnt, sat.
  - Used for match_cnt/cnt_sat.

Test Plan:
- PAT_W=4, load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 (in_valid=1) -> y=1 on bits 4 and 7; match_cnt=2.
- Load 4'b1010, stream 1,0,1,0,1,0:
  - overlap=1 -> y on bits 4 and 6, match_cnt=2.
  - overlap=0 -> y on bit 4 only, match_cnt=1.
- Stream 1,0,1,1 with in_valid low on cycles between bits -> y=1 only in the cycle of the 4th valid bit; no change while in_valid=0.
- Before any pat_load, stream 1,0,1,1 -> y stays 0 and match_cnt=0. Then pat_load with a=1, in_valid=1 -> load-cycle bit ignored, detection restarts.
- CNT_W=2, 4 matches -> match_cnt=3, cnt_sat=1 after the 3rd. cnt_clr coincident with a 5th match -> match_cnt=0.
- Drop reset_n low mid-window after 2 matched bits -> y=0 and match_cnt=0 immediately, state S_UNARMED; released stream without pat_load gives no matches.
